// File: rtl/machine_ctl_param_if.sv
// Handshake/strobe bundle between the accumulator-CPU sequencer and its datapath.
interface machine_ctl_param_if #(
  parameter int OPC_W  = 3,
  parameter int BEAT_W = 2
);
  logic [OPC_W-1:0]  opcode;
  logic              zero;
  logic              mem_rdy;
  logic              resume;
  logic              inc_pc;
  logic              load_acc;
  logic              load_pc;
  logic              rd;
  logic              wr;
  logic              load_ir;
  logic              datactl_ena;
  logic              halt;
  logic [BEAT_W-1:0] ir_beat;

  modport master (
    input  opcode, zero, mem_rdy, resume,
    output inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt, ir_beat
  );

  modport slave (
    output opcode, zero, mem_rdy, resume,
    input  inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt, ir_beat
  );
endinterface

// File: rtl/machine_ctl_param.sv
// Parametrised accumulator-CPU control sequencer: multi-beat fetch, optional
// memory wait states, sticky halt with resume. Everything updates on negedge clk1.
module machine_ctl_param #(
  parameter int FETCH_BEATS = 2,
  parameter int OPC_W       = 3,
  parameter int WAIT_EN     = 0,
  parameter int BEAT_W      = 2
) (
  input  logic                 clk1,
  input  logic                 rst,
  machine_ctl_param_if.master  bus
);
  typedef enum logic [2:0] {
    FETCH, IDLE1, DECODE, HALTED, OPFETCH, EXEC, IDLE2, SKIP
  } state_t;

  state_t            state, nxt_state;
  logic [BEAT_W-1:0] beat, nxt_beat;
  logic              zero_q;
  logic [OPC_W-1:0]  op;
  logic [7:0]        op_ext;
  logic              is_hlt, is_skz, is_alu, is_sto, is_jmp;
  logic              mem_phase, stall;
  logic              n_inc, n_acc, n_lpc, n_rd, n_wr, n_lir, n_den, n_halt;
  logic [BEAT_W-1:0] n_beat;

  // Zero-extend so that 4-bit codes >= 8 match no opcode and fall out as NOP.
  assign op     = bus.opcode;
  assign op_ext = 8'(op);
  assign is_hlt = (op_ext == 8'd0);
  assign is_skz = (op_ext == 8'd1);
  assign is_alu = (op_ext >= 8'd2) && (op_ext <= 8'd5);
  assign is_sto = (op_ext == 8'd6);
  assign is_jmp = (op_ext == 8'd7);

  always_comb begin
    n_inc     = 1'b0;
    n_acc     = 1'b0;
    n_lpc     = 1'b0;
    n_rd      = 1'b0;
    n_wr      = 1'b0;
    n_lir     = 1'b0;
    n_den     = 1'b0;
    n_halt    = 1'b0;
    n_beat    = '0;
    mem_phase = 1'b0;
    nxt_state = state;
    nxt_beat  = beat;
    case (state)
      FETCH: begin
        n_rd      = 1'b1;
        n_lir     = 1'b1;
        n_beat    = beat;
        n_inc     = (beat != '0);
        mem_phase = 1'b1;
        if (beat == BEAT_W'(FETCH_BEATS - 1)) begin
          nxt_state = IDLE1;
          nxt_beat  = '0;
        end else begin
          nxt_beat  = beat + BEAT_W'(1);
        end
      end
      IDLE1: nxt_state = DECODE;
      DECODE: begin
        n_inc = 1'b1;
        if (is_hlt) begin
          n_halt    = 1'b1;
          nxt_state = HALTED;
        end else begin
          nxt_state = OPFETCH;
        end
      end
      HALTED: begin
        if (bus.resume) nxt_state = FETCH;
        else            n_halt    = 1'b1;
      end
      OPFETCH: begin
        n_lpc     = is_jmp;
        n_rd      = is_alu;
        n_den     = is_sto;
        mem_phase = is_alu;
        nxt_state = EXEC;
      end
      EXEC: begin
        n_acc     = is_alu;
        n_rd      = is_alu;
        n_inc     = (is_skz && bus.zero) || is_jmp;
        n_lpc     = is_jmp;
        n_wr      = is_sto;
        n_den     = is_sto;
        mem_phase = is_alu || is_sto;
        nxt_state = IDLE2;
      end
      IDLE2: begin
        n_den     = is_sto;
        n_rd      = is_alu;
        mem_phase = is_alu;
        nxt_state = SKIP;
      end
      SKIP: begin
        n_inc     = is_skz && bus.zero && zero_q;
        nxt_state = FETCH;
      end
      default: nxt_state = FETCH;
    endcase

    // A stall keeps bus-level strobes asserted but suppresses the one-shot
    // load/increment strobes so each fires only on the advancing edge.
    stall = (WAIT_EN != 0) && mem_phase && !bus.mem_rdy;
    if (stall) begin
      n_inc     = 1'b0;
      n_lir     = 1'b0;
      n_acc     = 1'b0;
      n_lpc     = 1'b0;
      nxt_state = state;
      nxt_beat  = beat;
    end
  end

  always_ff @(negedge clk1) begin
    if (rst) begin
      state           <= FETCH;
      beat            <= '0;
      zero_q          <= 1'b0;
      bus.inc_pc      <= 1'b0;
      bus.load_acc    <= 1'b0;
      bus.load_pc     <= 1'b0;
      bus.rd          <= 1'b0;
      bus.wr          <= 1'b0;
      bus.load_ir     <= 1'b0;
      bus.datactl_ena <= 1'b0;
      bus.halt        <= 1'b0;
      bus.ir_beat     <= '0;
    end else begin
      state           <= nxt_state;
      beat            <= nxt_beat;
      if (state == EXEC) zero_q <= bus.zero;
      bus.inc_pc      <= n_inc;
      bus.load_acc    <= n_acc;
      bus.load_pc     <= n_lpc;
      bus.rd          <= n_rd;
      bus.wr          <= n_wr;
      bus.load_ir     <= n_lir;
      bus.datactl_ena <= n_den;
      bus.halt        <= n_halt;
      bus.ir_beat     <= n_beat;
    end
  end
endmodule
